// File: rtl/pixel_readout_capture.sv
// Sensor readout endpoint: follows the erase/expose/convert/read control sequence,
// captures a 2x2 pixel frame and streams it out as valid/ready bytes.
// Optional: define PIXEL_CHECKSUM_EN to append a modulo-2^DATA_W checksum byte per frame.
module pixel_readout_capture #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              erase,
  input  logic              expose,
  input  logic              convert,
  input  logic              read12,
  input  logic              read34,
  input  logic [DATA_W-1:0] pixData1,
  input  logic [DATA_W-1:0] pixData2,
  input  logic [DATA_W-1:0] pixData3,
  input  logic [DATA_W-1:0] pixData4,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              err_overflow,
  output logic              err_protocol
);

`ifdef PIXEL_CHECKSUM_EN
  localparam int unsigned NB = 5;
`else
  localparam int unsigned NB = 4;
`endif
  localparam int unsigned IDX_W = $clog2(NB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXPOSE, S_CONVERT, S_READ} state_t;

  state_t            state;
  logic [DATA_W-1:0] cap [4];
  logic              h12;
  logic              h34;
  logic              r12_q;
  logic              r34_q;
  logic [DATA_W-1:0] fb [NB];
  logic [IDX_W-1:0]  idx;

  logic [DATA_W-1:0] cap_n [4];
  logic              h12_n;
  logic              h34_n;
  logic              capturing;
  logic              done;
  logic              complete;
  logic              buf_free;

  // Capture view including this cycle's strobes, so a completing edge sees the latest bytes
  always_comb begin
    cap_n     = cap;
    h12_n     = h12;
    h34_n     = h34;
    capturing = (state == S_CONVERT) || (state == S_READ);
    if (capturing && read12) begin
      cap_n[0] = pixData1;
      cap_n[1] = pixData2;
      h12_n    = 1'b1;
    end
    if (capturing && read34) begin
      cap_n[2] = pixData3;
      cap_n[3] = pixData4;
      h34_n    = 1'b1;
    end
    done     = (state == S_READ) && r34_q && !read34;
    complete = done && h12_n && h34_n;
    // Buffer counts as free when its final byte is being accepted this cycle
    buf_free = !out_valid || (out_ready && out_last);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      h12          <= 1'b0;
      h34          <= 1'b0;
      r12_q        <= 1'b0;
      r34_q        <= 1'b0;
      idx          <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      frame_cnt    <= '0;
      err_overflow <= 1'b0;
      err_protocol <= 1'b0;
      for (int i = 0; i < 4; i++) cap[i] <= '0;
      for (int i = 0; i < int'(NB); i++) fb[i] <= '0;
    end else begin
      err_overflow <= 1'b0;
      err_protocol <= 1'b0;
      r12_q        <= read12;
      r34_q        <= read34;
      cap          <= cap_n;
      h12          <= h12_n;
      h34          <= h34_n;

      case (state)
        S_IDLE: begin
          if (erase) begin
            h12 <= 1'b0;
            h34 <= 1'b0;
          end
          if (expose) state <= S_EXPOSE;
        end
        S_EXPOSE: begin
          if (!expose && convert) state <= S_CONVERT;
        end
        S_CONVERT: begin
          if (read12 || read34) state <= S_READ;
        end
        S_READ: begin
          if (done) begin
            state <= S_IDLE;
            h12   <= 1'b0;
            h34   <= 1'b0;
            if (!(h12_n && h34_n)) err_protocol <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Strobes outside the conversion window are flagged once per rising edge
      if (!capturing && ((read12 && !r12_q) || (read34 && !r34_q))) err_protocol <= 1'b1;

      if (out_valid && out_ready) begin
        if (out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          idx      <= idx + IDX_W'(1);
          out_data <= fb[idx + IDX_W'(1)];
          out_last <= ((idx + IDX_W'(1)) == LAST_IDX);
        end
      end

      if (complete) begin
        if (buf_free) begin
          for (int i = 0; i < 4; i++) fb[i] <= cap_n[i];
`ifdef PIXEL_CHECKSUM_EN
          fb[NB-1] <= cap_n[0] + cap_n[1] + cap_n[2] + cap_n[3];
`endif
          idx       <= '0;
          out_data  <= cap_n[0];
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          frame_cnt <= frame_cnt + CNT_W'(1);
        end else begin
          err_overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_readout_capture.sv
// Directed bench for pixel_readout_capture: vector table plus multi-cycle corner sequences.
module tb_pixel_readout_capture;

  logic        clk = 1'b0;
  logic        reset, erase, expose, convert, read12, read34;
  logic [7:0]  pixData1, pixData2, pixData3, pixData4;
  logic [7:0]  out_data;
  logic        out_valid, out_ready, out_last;
  logic [15:0] frame_cnt;
  logic        err_overflow, err_protocol;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] RST = 6'b100000;
  localparam logic [5:0] ER  = 6'b010000;
  localparam logic [5:0] EX  = 6'b001000;
  localparam logic [5:0] CV  = 6'b000100;
  localparam logic [5:0] R12 = 6'b000010;
  localparam logic [5:0] R34 = 6'b000001;
  localparam logic [5:0] NO  = 6'b000000;

  typedef struct packed {
    logic [5:0]  ctl;
    logic [31:0] pix;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic        el;
    logic [15:0] ec;
    logic        eo;
    logic        ep;
  } vec_t;

  vec_t vecs[$];

  pixel_readout_capture #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .erase(erase), .expose(expose), .convert(convert),
    .read12(read12), .read34(read34),
    .pixData1(pixData1), .pixData2(pixData2), .pixData3(pixData3), .pixData4(pixData4),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_cnt(frame_cnt), .err_overflow(err_overflow), .err_protocol(err_protocol)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] ctl, input logic [31:0] pix);
    {reset, erase, expose, convert, read12, read34} = ctl;
    {pixData1, pixData2, pixData3, pixData4} = pix;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] ctl, input logic [31:0] pix, input logic rdy,
                     input logic ev, input logic [7:0] ed, input logic el,
                     input logic [15:0] ec, input logic eo, input logic ep);
    vec_t v;
    v = '{ctl: ctl, pix: pix, rdy: rdy, ev: ev, ed: ed, el: el, ec: ec, eo: eo, ep: ep};
    vecs.push_back(v);
  endtask

  task automatic frame(input logic [15:0] a, input logic [15:0] b);
    drive(EX, 32'h0);            step();
    drive(CV, 32'h0);            step();
    drive(R12, {a, 16'h0});      step();
    drive(R34, {16'h0, b});      step();
    drive(NO, 32'h0);            step();
  endtask

  // Accept a whole frame with ready held high; bytes must arrive on consecutive cycles
  task automatic drain(input string nm, input logic [31:0] exp);
    int n = 0;
    int c = 0;
    logic [7:0] eb;
    out_ready = 1'b1;
    while (n < 4 && c < 20) begin
      if (out_valid) begin
        eb = exp[31-8*n -: 8];
        chk($sformatf("%s byte%0d", nm, n), {out_last, out_data}, {(n == 3), eb});
        n++;
      end
      step();
      c++;
    end
    chk({nm, " cycles"}, 64'(c), 64'd4);
    chk({nm, " valid_after"}, 64'(out_valid), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] act, exp;
    logic [2:0]  pat;
    logic [7:0]  hd;
    logic        hl, held;
    int          n, c;

    drive(NO, 32'h0);
    out_ready = 1'b0;

    // Nominal frame
    add(RST, 32'h0, 0, 0, 8'h00, 0, 16'd0, 0, 0);
    add(ER,  32'h0, 0, 0, 8'h00, 0, 16'd0, 0, 0);
    add(EX,  32'h0, 0, 0, 8'h00, 0, 16'd0, 0, 0);
    add(EX,  32'h0, 0, 0, 8'h00, 0, 16'd0, 0, 0);
    add(EX,  32'h0, 0, 0, 8'h00, 0, 16'd0, 0, 0);
    add(CV,  32'h0, 0, 0, 8'h00, 0, 16'd0, 0, 0);
    add(CV,  32'h0, 0, 0, 8'h00, 0, 16'd0, 0, 0);
    add(R12, 32'h11220000, 0, 0, 8'h00, 0, 16'd0, 0, 0);
    add(R34, 32'h00003344, 0, 0, 8'h00, 0, 16'd0, 0, 0);
    add(NO,  32'h0, 1, 1, 8'h11, 0, 16'd1, 0, 0);
    add(NO,  32'h0, 1, 1, 8'h22, 0, 16'd1, 0, 0);
    add(NO,  32'h0, 1, 1, 8'h33, 0, 16'd1, 0, 0);
    add(NO,  32'h0, 1, 1, 8'h44, 1, 16'd1, 0, 0);
    add(NO,  32'h0, 1, 0, 8'h00, 0, 16'd1, 0, 0);
    // read12 in IDLE: one pulse per rising edge
    add(R12, 32'hDEAD0000, 0, 0, 8'h00, 0, 16'd1, 0, 1);
    add(R12, 32'hDEAD0000, 0, 0, 8'h00, 0, 16'd1, 0, 0);
    add(NO,  32'h0, 0, 0, 8'h00, 0, 16'd1, 0, 0);
    // read34-only frame is dropped
    add(EX,  32'h0, 0, 0, 8'h00, 0, 16'd1, 0, 0);
    add(CV,  32'h0, 0, 0, 8'h00, 0, 16'd1, 0, 0);
    add(R34, 32'h0000BEEF, 0, 0, 8'h00, 0, 16'd1, 0, 0);
    add(NO,  32'h0, 0, 0, 8'h00, 0, 16'd1, 0, 1);
    add(NO,  32'h0, 0, 0, 8'h00, 0, 16'd1, 0, 0);
    // Overflow: second frame dropped while first is stalled
    add(RST, 32'h0, 0, 0, 8'h00, 0, 16'd0, 0, 0);
    add(EX,  32'h0, 0, 0, 8'h00, 0, 16'd0, 0, 0);
    add(CV,  32'h0, 0, 0, 8'h00, 0, 16'd0, 0, 0);
    add(R12, 32'h01020000, 0, 0, 8'h00, 0, 16'd0, 0, 0);
    add(R34, 32'h00000304, 0, 0, 8'h00, 0, 16'd0, 0, 0);
    add(NO,  32'h0, 0, 1, 8'h01, 0, 16'd1, 0, 0);
    add(EX,  32'h0, 0, 1, 8'h01, 0, 16'd1, 0, 0);
    add(CV,  32'h0, 0, 1, 8'h01, 0, 16'd1, 0, 0);
    add(R12, 32'h05060000, 0, 1, 8'h01, 0, 16'd1, 0, 0);
    add(R34, 32'h00000708, 0, 1, 8'h01, 0, 16'd1, 0, 0);
    add(NO,  32'h0, 0, 1, 8'h01, 0, 16'd1, 1, 0);
    add(NO,  32'h0, 1, 1, 8'h02, 0, 16'd1, 0, 0);
    add(NO,  32'h0, 1, 1, 8'h03, 0, 16'd1, 0, 0);
    add(NO,  32'h0, 1, 1, 8'h04, 1, 16'd1, 0, 0);
    add(NO,  32'h0, 1, 0, 8'h00, 0, 16'd1, 0, 0);
    // Completion on the same edge as the final byte's acceptance still loads
    add(EX,  32'h0, 0, 0, 8'h00, 0, 16'd1, 0, 0);
    add(CV,  32'h0, 0, 0, 8'h00, 0, 16'd1, 0, 0);
    add(R12, 32'h21220000, 0, 0, 8'h00, 0, 16'd1, 0, 0);
    add(R34, 32'h00002324, 0, 0, 8'h00, 0, 16'd1, 0, 0);
    add(NO,  32'h0, 0, 1, 8'h21, 0, 16'd2, 0, 0);
    add(EX,  32'h0, 0, 1, 8'h21, 0, 16'd2, 0, 0);
    add(CV,  32'h0, 1, 1, 8'h22, 0, 16'd2, 0, 0);
    add(R12, 32'h31320000, 1, 1, 8'h23, 0, 16'd2, 0, 0);
    add(R34, 32'h00003334, 1, 1, 8'h24, 1, 16'd2, 0, 0);
    add(NO,  32'h0, 1, 1, 8'h31, 0, 16'd3, 0, 0);
    add(NO,  32'h0, 1, 1, 8'h32, 0, 16'd3, 0, 0);
    add(NO,  32'h0, 1, 1, 8'h33, 0, 16'd3, 0, 0);
    add(NO,  32'h0, 1, 1, 8'h34, 1, 16'd3, 0, 0);
    add(NO,  32'h0, 1, 0, 8'h00, 0, 16'd3, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].ctl, vecs[i].pix);
      out_ready = vecs[i].rdy;
      step();
      act = {out_valid, (out_valid ? out_data : 8'h00), out_last, frame_cnt, err_overflow, err_protocol};
      exp = {vecs[i].ev, (vecs[i].ev ? vecs[i].ed : 8'h00), vecs[i].el, vecs[i].ec, vecs[i].eo, vecs[i].ep};
      chk($sformatf("row%0d {v,d,l,cnt,ovf,perr}", i), act, exp);
    end

    // Held read12: last sampled value wins
    out_ready = 1'b0;
    drive(RST, 32'h0); step();
    drive(EX, 32'h0);  step();
    drive(CV, 32'h0);  step();
    drive(R12, 32'hA0B00000); step();
    drive(R12, 32'hA1B00000); step();
    drive(R12, 32'hA2B00000); step();
    drive(R34, 32'h0000C0C1); step();
    drive(NO, 32'h0);         step();
    drain("held", 32'hA2B0C0C1);

    // Both strobes in one cycle
    drive(EX, 32'h0); step();
    drive(CV, 32'h0); step();
    drive(R12 | R34, 32'h5A6B7C8D); step();
    drive(NO, 32'h0); step();
    drain("simul", 32'h5A6B7C8D);
    chk("simul frame_cnt", 64'(frame_cnt), 64'd2);

    // Backpressure with ready pattern 1,0,0
    drive(RST, 32'h0); step();
    drive(NO, 32'h0);
    frame(16'h1122, 16'h3344);
    n = 0;
    c = 0;
    pat = 3'b100;
    while (n < 4 && c < 40) begin
      out_ready = pat[2];
      pat = {pat[1:0], pat[2]};
      if (out_valid && out_ready) begin
        hd = 8'(32'h11223344 >> (24 - 8*n));
        chk($sformatf("bp byte%0d", n), {out_last, out_data}, {(n == 3), hd});
        n++;
      end
      held = out_valid && !out_ready;
      hd = out_data;
      hl = out_last;
      step();
      c++;
      if (held) chk($sformatf("bp hold c%0d", c), {out_valid, out_last, out_data}, {1'b1, hl, hd});
    end
    chk("bp transfers", 64'(n), 64'd4);
    out_ready = 1'b1;
    step();
    chk("bp no_extra", 64'(out_valid), 64'd0);
    chk("bp frame_cnt", 64'(frame_cnt), 64'd1);

    // Reset after two bytes transferred
    out_ready = 1'b0;
    frame(16'h6162, 16'h6364);
    out_ready = 1'b1;
    step();
    step();
    chk("mid pre_reset data", 64'(out_data), 64'h63);
    drive(RST, 32'h0); step();
    chk("mid reset {v,l,cnt}", {out_valid, out_last, frame_cnt}, {1'b0, 1'b0, 16'd0});
    drive(NO, 32'h0);
    step(); step(); step();
    chk("mid idle valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    frame(16'h7172, 16'h7374);
    drain("post_reset", 32'h71727374);
    chk("post_reset frame_cnt", 64'(frame_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_readout_capture.md
Name: pixel_readout_capture

Overview:
- Receive-side endpoint of the sensor readout interface.
- Tracks the erase/expose/convert/read12/read34 control sequence from the pixel array controller.
- Samples the four 8-bit pixel buses during the read strobes and assembles one 2x2 frame.
- Serialises each completed frame onto a valid/ready byte stream for the downstream image pipeline.

Parameters:
- DATA_W, 8, width of each pixel bus and of the output byte.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- erase  input  1  sensor erase phase.
- expose  input  1  sensor exposure phase.
- convert  input  1  sensor ADC conversion phase.
- read12  input  1  pixels 1/2 valid on pixData1/pixData2.
- read34  input  1  pixels 3/4 valid on pixData3/pixData4.
- pixData1..pixData4  input  DATA_W each  pixel buses; only meaningful while the matching read strobe is high.
- out_data  output  DATA_W  stream byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts byte.
- out_last  output  1  final byte of the frame.
- frame_cnt  output  CNT_W  frames successfully queued for output.
- err_overflow  output  1  one-cycle pulse: completed frame dropped, output buffer busy.
- err_protocol  output  1  one-cycle pulse: read strobe outside CONVERT/READ, or incomplete frame.

Behaviour:
- Reset, synchronous, active-high, wins over all else:
  - FSM returns to IDLE.
  - Capture bytes and flags h12/h34 are cleared.
  - Output buffer is emptied.
  - out_valid=0, out_data=0, out_last=0, frame_cnt=0, both error pulses 0.
- Reset mid-frame or mid-stream discards all partial data; no byte is emitted after reset until a new full frame completes.
- FSM states IDLE, EXPOSE, CONVERT, READ:
  - IDLE: erase=1 clears h12/h34 and stays in IDLE. expose=1 goes to EXPOSE.
  - EXPOSE: expose=0 and convert=1 goes to CONVERT; otherwise stay.
  - CONVERT: read12 or read34 high goes to READ and captures in the same cycle.
  - READ: captures while strobes are high. read34 falling edge (prev=1, now=0) completes the frame, then IDLE.
- Capture:
  - Each clk edge with read12=1 latches pixData1 into byte0, pixData2 into byte1, and sets h12.
  - Each clk edge with read34=1 latches pixData3 into byte2, pixData4 into byte3, and sets h34.
  - Multi-cycle strobes: the last sampled value wins.
  - read12 and read34 high in the same cycle: both captured.
- Completion:
  - If h12 and h34 are both set: frame is complete.
  - If either is missing: frame is dropped, err_protocol pulses, no count.
  - h12/h34 clear on completion.
- Read strobe seen in IDLE or EXPOSE: ignored, no capture, err_protocol pulses once per rising edge of the strobe.
- Output buffer (one frame deep):
  - On a complete frame with the buffer empty: copy 4 bytes, frame_cnt+1 (wraps modulo 2^CNT_W), out_valid=1 from the next cycle.
  - If the buffer is still streaming: frame dropped, err_overflow pulses, frame_cnt unchanged.
  - A completion in the same cycle as acceptance of the final byte loads successfully (buffer counts as free that cycle).
- Stream:
  - Byte order: byte0, byte1, byte2, byte3.
  - A byte transfers on out_valid&&out_ready.
  - out_data and out_last hold stable while out_valid=1 and out_ready=0.
  - out_last=1 only with the final byte.
  - Back-to-back ready gives 4 bytes in 4 consecutive cycles.
  - out_valid drops the cycle after the final transfer.
- Latency: completing edge at cycle N gives first byte valid at N+1.

Optional Feature:
- Macro PIXEL_CHECKSUM_EN.
- Defined:
  - A fifth byte is appended: (byte0+byte1+byte2+byte3) mod 2^DATA_W.
  - out_last moves to the checksum byte.
  - The buffer stays busy until the checksum transfers.
- Undefined: 4-byte frames exactly as above; no checksum logic.

Test Plan:
- Nominal frame: reset, erase, expose 3 cycles, convert 2, read12 with pix1=0x11/pix2=0x22, read34 with 0x33/0x44, out_ready=1.
  - Expect 0x11,0x22,0x33,0x44 on consecutive cycles starting 1 cycle after read34 falls, out_last on 0x44, frame_cnt=1.
  - With PIXEL_CHECKSUM_EN: fifth byte 0xAA with out_last.
- Backpressure: nominal frame, out_ready toggling 1,0,0,1,...
  - Expect each byte held stable while stalled, no duplicates or drops, exactly 4 transfers (5 with checksum).
- Overflow: out_ready=0, complete two frames (0x01..0x04, then 0x05..0x08).
  - Expect err_overflow pulse at the second completion, frame_cnt=1.
  - Releasing ready yields only 0x01..0x04.
- Protocol errors:
  - read12 pulsed in IDLE: err_protocol pulse, no capture.
  - Frame with read34 only: err_protocol at read34 fall, no output, frame_cnt unchanged.
- Strobe corner cases:
  - read12 held 3 cycles with pixData1=0xA0,0xA1,0xA2: byte0 = 0xA2.
  - read12 and read34 simultaneous for 1 cycle: all four bytes captured.
- Reset mid-stream: assert reset after 2 bytes transferred.
  - Expect out_valid=0 and frame_cnt=0 the next cycle.
  - Next full frame streams normally from byte0.
